// File: rtl/memcpy_cmd_arb_if.sv
// Requester, memcpy tx (command) and rx (completion) signals of memcpy_cmd_arb.
// slave = arbiter side, master = requesters plus the memcpy queues.
interface memcpy_cmd_arb_if #(
    parameter int NREQ    = 4,
    parameter int SRCID_W = 8
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [64*NREQ-1:0]   req_dst;
    logic [64*NREQ-1:0]   req_src;
    logic [64*NREQ-1:0]   req_num;
    logic                 cmd_tx;
    logic                 cmd_txFull;
    logic [SRCID_W-1:0]   cmd_srcid;
    logic [SRCID_W-1:0]   cmd_dstid;
    logic [63:0]          cmd_arg0;
    logic [63:0]          cmd_arg1;
    logic [63:0]          cmd_arg2;
    logic [63:0]          cmd_arg3;
    logic                 rsp_rxEmpty;
    logic [SRCID_W-1:0]   rsp_srcid;
    logic                 rsp_rxPop;

    modport slave (
        input  req_valid, req_dst, req_src, req_num,
        input  cmd_txFull, rsp_rxEmpty, rsp_srcid,
        output req_ready, cmd_tx, cmd_srcid, cmd_dstid,
        output cmd_arg0, cmd_arg1, cmd_arg2, cmd_arg3,
        output rsp_rxPop
    );

    modport master (
        output req_valid, req_dst, req_src, req_num,
        output cmd_txFull, rsp_rxEmpty, rsp_srcid,
        input  req_ready, cmd_tx, cmd_srcid, cmd_dstid,
        input  cmd_arg0, cmd_arg1, cmd_arg2, cmd_arg3,
        input  rsp_rxPop
    );
endinterface

// File: rtl/memcpy_cmd_arb.sv
// Round-robin arbiter sharing one memcpy client port among NREQ requesters,
// with per-requester busy tracking, a global credit cap and done routing.
module memcpy_cmd_arb #(
    parameter int NREQ    = 4,
    parameter int MAX_OUT = 2,
    parameter int SRCID_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    memcpy_cmd_arb_if.slave              io,
    output logic [NREQ-1:0]              busy,
    output logic [NREQ-1:0]              done_pulse,
    output logic                         err_pulse,
    output logic [$clog2(MAX_OUT+1)-1:0] credits
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NREQ-1:0]    busy_q, busy_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cred_q, cred_d;
    logic               tx_q, tx_d;
    logic [SRCID_W-1:0] srcid_q, srcid_d;
    logic [63:0]        a0_q, a0_d, a1_q, a1_d;
    logic [63:0]        a2_q, a2_d, a3_q, a3_d;

    logic [NREQ-1:0]    elig, gnt, hit;
    logic [PW-1:0]      gidx;
    logic               accept, pop;
    logic [63:0]        dst_s, src_s, num_s;

    assign pop          = !io.rsp_rxEmpty;
    assign io.rsp_rxPop = pop;
    assign io.req_ready = gnt;

    always_comb begin
        int idx;
        idx  = 0;
        // rst gates grants so nothing is handed out that cannot be taken
        elig = io.req_valid & ~busy_q
             & {NREQ{!io.cmd_txFull && cred_q != '0 && !rst}};
        gnt  = '0;
        gidx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (gnt == '0 && elig[idx]) begin
                gnt[idx] = 1'b1;
                gidx     = PW'(idx);
            end
        end
        accept = |gnt;
        for (int i = 0; i < NREQ; i++) begin
            hit[i] = pop && io.rsp_srcid == SRCID_W'(i) && busy_q[i];
        end
    end

    always_comb begin
        dst_s   = io.req_dst[64*int'(gidx) +: 64];
        src_s   = io.req_src[64*int'(gidx) +: 64];
        num_s   = io.req_num[64*int'(gidx) +: 64];
        ptr_d   = ptr_q;
        srcid_d = srcid_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        a3_d    = a3_q;
        tx_d    = accept;
        busy_d  = (busy_q & ~hit) | gnt;
        done_d  = hit;
        err_d   = pop && hit == '0;
        cred_d  = cred_q;
        if (accept && hit == '0) begin
            cred_d = cred_q - CW'(1);
        end else if (!accept && hit != '0) begin
            cred_d = cred_q + CW'(1);
        end
        if (accept) begin
            ptr_d   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
            srcid_d = SRCID_W'(gidx);
            a0_d    = num_s[32] ? dst_s >> 6 : dst_s;
            a1_d    = num_s[32] ? src_s : src_s >> 6;
            a2_d    = {32'd0, num_s[31:0]};
            a3_d    = {32'd0, num_s[63:32]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            cred_q  <= CW'(MAX_OUT);
            tx_q    <= 1'b0;
            srcid_q <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cred_q  <= cred_d;
            tx_q    <= tx_d;
            srcid_q <= srcid_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            a3_q    <= a3_d;
        end
    end

    assign io.cmd_tx    = tx_q;
    assign io.cmd_srcid = srcid_q;
    assign io.cmd_dstid = '0;
    assign io.cmd_arg0  = a0_q;
    assign io.cmd_arg1  = a1_q;
    assign io.cmd_arg2  = a2_q;
    assign io.cmd_arg3  = a3_q;
    assign busy         = busy_q;
    assign done_pulse   = done_q;
    assign err_pulse    = err_q;
    assign credits      = cred_q;
endmodule

// File: tb/tb_memcpy_cmd_arb.sv
// Bench for memcpy_cmd_arb: dut_a (MAX_OUT=2) with a grant/command scoreboard,
// dut_b (MAX_OUT=4) for the plain round-robin sweep.
module tb_memcpy_cmd_arb;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memcpy_cmd_arb_if #(.NREQ(N), .SRCID_W(8)) ifa ();
    memcpy_cmd_arb_if #(.NREQ(N), .SRCID_W(8)) ifb ();

    logic [N-1:0] busy_a, done_a, busy_b, done_b;
    logic         err_a, err_b;
    logic [1:0]   cred_a;
    logic [2:0]   cred_b;

    memcpy_cmd_arb #(.NREQ(N), .MAX_OUT(2), .SRCID_W(8)) dut_a (
        .clk(clk), .rst(rst), .io(ifa),
        .busy(busy_a), .done_pulse(done_a),
        .err_pulse(err_a), .credits(cred_a)
    );

    memcpy_cmd_arb #(.NREQ(N), .MAX_OUT(4), .SRCID_W(8)) dut_b (
        .clk(clk), .rst(rst), .io(ifb),
        .busy(busy_b), .done_pulse(done_b),
        .err_pulse(err_b), .credits(cred_b)
    );

    logic [63:0] dst_t [N];
    logic [63:0] src_t [N];
    logic [63:0] num_t [N];

    int checks = 0;
    int errors = 0;
    int exp_gnt [$];
    int exp_cmd [$];
    logic [N-1:0] acc_a = '0;
    logic [N-1:0] set_a = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_arg(input int i, input int k);
        case (k)
            0:       return num_t[i][32] ? dst_t[i] >> 6 : dst_t[i];
            1:       return num_t[i][32] ? src_t[i] : src_t[i] >> 6;
            2:       return {32'd0, num_t[i][31:0]};
            default: return {32'd0, num_t[i][63:32]};
        endcase
    endfunction

    always @(negedge clk) begin
        int e;
        acc_a = '0;
        if (!rst) begin
            acc_a = ifa.req_valid & ifa.req_ready;
            if (acc_a != '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexp", 64'(acc_a), 64'd0);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt", 64'(ifa.req_ready), 64'd1 << e);
                    exp_cmd.push_back(e);
                end
            end
            if (ifa.cmd_tx) begin
                if (exp_cmd.size() == 0) begin
                    chk("tx_unexp", 64'(ifa.cmd_tx), 64'd0);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("srcid", 64'(ifa.cmd_srcid), 64'(e));
                    chk("dstid", 64'(ifa.cmd_dstid), 64'd0);
                    chk("arg0", ifa.cmd_arg0, exp_arg(e, 0));
                    chk("arg1", ifa.cmd_arg1, exp_arg(e, 1));
                    chk("arg2", ifa.cmd_arg2, exp_arg(e, 2));
                    chk("arg3", ifa.cmd_arg3, exp_arg(e, 3));
                end
            end
        end
    end

    // requesters hold valid until accepted, then drop it
    always @(posedge clk) begin
        #1;
        ifa.req_valid = (ifa.req_valid & ~acc_a) | set_a;
        set_a = '0;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rsp(input logic [7:0] id);
        ifa.rsp_srcid   = id;
        ifa.rsp_rxEmpty = 1'b0;
        #1;
        chk("pop", 64'(ifa.rsp_rxPop), 64'd1);
        cyc();
        ifa.rsp_rxEmpty = 1'b1;
    endtask

    initial begin
        dst_t[0] = 64'h1000;
        src_t[0] = 64'h2000;
        num_t[0] = 64'h0000_0000_0000_0010;
        dst_t[1] = 64'h4000;
        src_t[1] = 64'h5000;
        num_t[1] = 64'h0000_0001_0000_0020;
        dst_t[2] = 64'h8000_0000_0000_0040;
        src_t[2] = 64'h3;
        num_t[2] = 64'h0000_0002_0000_0005;
        dst_t[3] = 64'hFFFF_FFFF_FFFF_FFC0;
        src_t[3] = 64'h1234_5678;
        num_t[3] = 64'h0000_0003_0000_0007;
        for (int i = 0; i < N; i++) begin
            ifa.req_dst[64*i +: 64] = dst_t[i];
            ifa.req_src[64*i +: 64] = src_t[i];
            ifa.req_num[64*i +: 64] = num_t[i];
            ifb.req_dst[64*i +: 64] = dst_t[i];
            ifb.req_src[64*i +: 64] = src_t[i];
            ifb.req_num[64*i +: 64] = num_t[i];
        end
        ifa.req_valid   = '0;
        ifb.req_valid   = '0;
        ifa.cmd_txFull  = 1'b0;
        ifb.cmd_txFull  = 1'b0;
        ifa.rsp_rxEmpty = 1'b1;
        ifb.rsp_rxEmpty = 1'b1;
        ifa.rsp_srcid   = '0;
        ifb.rsp_srcid   = '0;

        cyc();
        cyc();
        chk("rst_tx", 64'(ifa.cmd_tx), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_cred", 64'(cred_a), 64'd2);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_arg0", ifa.cmd_arg0, 64'd0);
        chk("rst_cred_b", 64'(cred_b), 64'd4);
        rst = 1'b0;
        cyc();

        ifb.req_valid = 4'hF;
        #1;
        for (int k = 0; k < N; k++) begin
            chk("rr_gnt", 64'(ifb.req_ready), 64'd1 << k);
            cyc();
            chk("rr_tx", 64'(ifb.cmd_tx), 64'd1);
            chk("rr_src", 64'(ifb.cmd_srcid), 64'(k));
            chk("rr_arg0", ifb.cmd_arg0, exp_arg(k, 0));
        end
        chk("rr_cred", 64'(cred_b), 64'd0);
        chk("rr_busy", 64'(busy_b), 64'hF);
        chk("rr_rdy0", 64'(ifb.req_ready), 64'd0);
        cyc();
        chk("rr_rdy1", 64'(ifb.req_ready), 64'd0);
        chk("rr_txlo", 64'(ifb.cmd_tx), 64'd0);

        exp_gnt.push_back(0);
        set_a = 4'b0001;
        cyc();
        chk("s1_rdy", 64'(ifa.req_ready), 64'd1);
        cyc();
        chk("s1_tx", 64'(ifa.cmd_tx), 64'd1);
        chk("s1_src", 64'(ifa.cmd_srcid), 64'd0);
        chk("s1_arg0", ifa.cmd_arg0, 64'h1000);
        chk("s1_arg1", ifa.cmd_arg1, 64'h80);
        chk("s1_arg2", ifa.cmd_arg2, 64'h10);
        chk("s1_arg3", ifa.cmd_arg3, 64'h0);
        chk("s1_busy", 64'(busy_a), 64'd1);
        chk("s1_cred", 64'(cred_a), 64'd1);
        chk("s1_rdy0", 64'(ifa.req_ready), 64'd0);
        cyc();
        chk("s1_txlo", 64'(ifa.cmd_tx), 64'd0);
        chk("s1_hold", ifa.cmd_arg0, 64'h1000);

        rsp(8'd0);
        chk("c_done", 64'(done_a), 64'd1);
        chk("c_busy", 64'(busy_a), 64'd0);
        chk("c_cred", 64'(cred_a), 64'd2);
        cyc();
        chk("c_done0", 64'(done_a), 64'd0);

        exp_gnt.push_back(1);
        exp_gnt.push_back(2);
        set_a = 4'hF;
        cyc();
        chk("cr_rdy1", 64'(ifa.req_ready), 64'b0010);
        cyc();
        chk("cr_rdy2", 64'(ifa.req_ready), 64'b0100);
        cyc();
        chk("cr_cred0", 64'(cred_a), 64'd0);
        cyc();
        chk("cr_stall", 64'(ifa.req_ready), 64'd0);
        chk("cr_busy", 64'(busy_a), 64'b0110);

        ifa.cmd_txFull = 1'b1;
        rsp(8'd1);
        chk("bp_done", 64'(done_a), 64'b0010);
        chk("bp_busy", 64'(busy_a), 64'b0100);
        chk("bp_cred", 64'(cred_a), 64'd1);
        chk("bp_rdy", 64'(ifa.req_ready), 64'd0);
        cyc();
        chk("bp_hold", 64'(ifa.req_ready), 64'd0);
        exp_gnt.push_back(3);
        ifa.cmd_txFull = 1'b0;
        #1;
        chk("bp_rdy3", 64'(ifa.req_ready), 64'b1000);
        cyc();
        chk("bp_tx", 64'(ifa.cmd_tx), 64'd1);
        chk("bp_cred0", 64'(cred_a), 64'd0);
        chk("bp_busy2", 64'(busy_a), 64'b1100);

        exp_gnt.push_back(0);
        rsp(8'd2);
        chk("g0_rdy", 64'(ifa.req_ready), 64'b0001);
        cyc();
        chk("g0_busy", 64'(busy_a), 64'b1001);
        chk("g0_cred", 64'(cred_a), 64'd0);

        exp_gnt.push_back(2);
        rsp(8'd0);
        chk("sim_cred1", 64'(cred_a), 64'd1);
        set_a = 4'b0100;
        cyc();
        chk("sim_rdy", 64'(ifa.req_ready), 64'b0100);
        rsp(8'd3);
        chk("sim_cred", 64'(cred_a), 64'd1);
        chk("sim_busy", 64'(busy_a), 64'b0100);
        chk("sim_done", 64'(done_a), 64'b1000);
        chk("sim_err", 64'(err_a), 64'd0);

        rsp(8'd5);
        chk("u5_err", 64'(err_a), 64'd1);
        chk("u5_cred", 64'(cred_a), 64'd1);
        chk("u5_busy", 64'(busy_a), 64'b0100);
        chk("u5_done", 64'(done_a), 64'd0);
        cyc();
        chk("u5_err0", 64'(err_a), 64'd0);
        rsp(8'd1);
        chk("u1_err", 64'(err_a), 64'd1);
        chk("u1_cred", 64'(cred_a), 64'd1);
        chk("u1_busy", 64'(busy_a), 64'b0100);

        exp_gnt.push_back(0);
        set_a = 4'b0001;
        cyc();
        chk("rm_rdy", 64'(ifa.req_ready), 64'b0001);
        cyc();
        chk("rm_busy", 64'(busy_a), 64'b0101);
        chk("rm_cred", 64'(cred_a), 64'd0);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("rm_tx", 64'(ifa.cmd_tx), 64'd0);
        chk("rm_busy0", 64'(busy_a), 64'd0);
        chk("rm_cred2", 64'(cred_a), 64'd2);
        chk("rm_done", 64'(done_a), 64'd0);
        chk("rm_err", 64'(err_a), 64'd0);
        chk("rm_arg0", ifa.cmd_arg0, 64'd0);
        chk("rm_src", 64'(ifa.cmd_srcid), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        rsp(8'd0);
        chk("rm_late_err", 64'(err_a), 64'd1);
        chk("rm_late_busy", 64'(busy_a), 64'd0);
        chk("rm_late_cred", 64'(cred_a), 64'd2);
        cyc();

        chk("q_gnt", 64'(exp_gnt.size()), 64'd0);
        chk("q_cmd", 64'(exp_cmd.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/memcpy_cmd_arb.md
Name: memcpy_cmd_arb

Overview:
- Shares one memcpy service client port among NREQ software/hardware command sources.
- Arbitrates round-robin and formats each command as an active message, tagging srcid with the requester index.
- Tracks one outstanding command per requester plus a global credit limit, and routes completion messages back to the requester as done pulses.
- Sits between the CSR/command generators and the memcpy server's client-side tx/rx queues.

Parameters:
- NREQ, 4, number of requesters (2..16)
- MAX_OUT, 2, global cap on outstanding commands (1..NREQ)
- SRCID_W, 8, width of message srcid/dstid fields

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  requester i has a command pending (level)
- req_ready  out  NREQ  one-hot grant; command accepted when valid&ready
- req_dst  in  64*NREQ  destination address, slice i
- req_src  in  64*NREQ  source address, slice i
- req_num  in  64*NREQ  [31:0] line count, [63:32] command word, slice i
- cmd_tx  out  1  message enqueue strobe to memcpy tx queue
- cmd_txFull  in  1  memcpy tx queue full
- cmd_srcid  out  SRCID_W  requester index
- cmd_dstid  out  SRCID_W  constant 0
- cmd_arg0..cmd_arg3  out  64 each  message arguments
- rsp_rxEmpty  in  1  completion queue empty
- rsp_srcid  in  SRCID_W  srcid of head completion message
- rsp_rxPop  out  1  pop completion queue
- busy  out  NREQ  requester i has a command outstanding
- done_pulse  out  NREQ  one-cycle completion pulse for requester i
- err_pulse  out  1  one-cycle pulse on an unmatched completion
- credits  out  $clog2(MAX_OUT+1)  free global slots

Behaviour:
- Reset, asynchronous: cmd_tx, cmd_srcid, cmd_arg*, busy, done_pulse, err_pulse = 0; credits = MAX_OUT; round-robin pointer = 0. Asserting rst mid-operation drops all outstanding state. Completions that arrive later are flagged as errors.
- Eligibility (combinational): requester i is eligible iff req_valid[i] && !busy[i] && !cmd_txFull && credits>0.
- Arbitration: the first eligible index scanning pointer, pointer+1, ... mod NREQ gets req_ready high that cycle; at most one bit is set.
- Pointer update: on an accepted grant the pointer becomes grant+1 mod NREQ; otherwise it holds.
- Issue latency: one cycle. The cycle after acceptance, cmd_tx=1 and the registered fields carry the granted requester's slice:
  - srcid = i; dstid = 0
  - arg0 = num[32] ? dst>>6 : dst
  - arg1 = num[32] ? src : src>>6
  - arg2 = {32'd0, num[31:0]}
  - arg3 = {32'd0, num[63:32]}
- cmd_tx is low in every cycle without a preceding accept. Fields hold their last value when cmd_tx=0.
- Issue side effects: busy[i] is set and credits decrement in the same edge that raises cmd_tx.
- Completion: rsp_rxPop = !rsp_rxEmpty (combinational; one message popped per cycle). Let r = rsp_srcid at the pop.
  - If r<NREQ && busy[r]: next cycle busy[r]=0, done_pulse[r]=1, credits increment.
  - Otherwise: err_pulse=1 next cycle; busy and credits are unchanged.
- Simultaneous issue and completion in one cycle: credits net unchanged; the busy bits of different requesters update independently. The same requester cannot be granted while busy, so a grant and a completion never hit the same index.
- A completion for i in cycle t clears busy[i] at t+1, so i can be granted again from t+1.
- Credits never exceed MAX_OUT and never underflow; a grant is blocked at 0.
- cmd_txFull rising in the accept cycle is impossible: eligibility already requires !cmd_txFull that cycle.

Test Plan:
- Single request: req_valid[0]=1, dst=0x1000, src=0x2000, num=0x0000_0000_0000_0010, txFull=0 -> req_ready[0] for 1 cycle; next cycle cmd_tx=1, arg0=0x1000, arg1=0x80, arg2=0x10, arg3=0, srcid=0; busy[0]=1, credits=1.
- Round-robin: req_valid=4'b1111 held, MAX_OUT=4, no completions -> grants in order 0,1,2,3 on consecutive cycles; credits reach 0; req_ready=0 thereafter.
- Completion routing: after the issue in the first scenario, push a completion with srcid=0 -> rsp_rxPop=1; next cycle done_pulse=4'b0001, busy[0]=0, credits back to 2.
- Credit and backpressure: MAX_OUT=2, all valid -> exactly 2 issues, then stall. Hold cmd_txFull=1 and complete one -> no grant until txFull drops, then one issue.
- Unmatched completion: srcid=5 (>=NREQ), then srcid=1 while busy[1]=0 -> err_pulse on each; credits and busy unchanged.
- Reset mid-flight: two outstanding, assert rst asynchronously -> all outputs 0 and credits=MAX_OUT immediately. A subsequent completion with srcid=0 -> err_pulse=1.
